execute: RTL and testbench

Execute stage of the MIPS pipeline. It sits directly downstream of decode and consumes the decoded fields plus register-file operands. Each cycle it registers an ALU result, load/store control, branch/jump resolution and destination-register info. An internal iterative multiply/divide unit (MDU) owns the HI/LO registers and stalls decode only when a dependent instruction arrives.

---
 rtl/mips_defs.sv | 65 ++++++
 rtl/execute_mdu.sv | 125 ++++++++++++
 rtl/execute.sv | 159 +++++++++++++++
 tb/tb_execute.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS execute-stage definitions: widths, opcode/func encodings,
// MDU state and operation types, plus the HI/LO dependency helper.
package mips_defs;

   localparam int DATA_WIDTH = 32;
   localparam int REG_WIDTH  = 5;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   typedef enum logic {MDU_IDLE, MDU_BUSY} mdu_state_t;

   // Encoded to match func[1:0] of MULT/MULTU/DIV/DIVU.
   typedef enum logic [1:0] {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU} mdu_op_t;

   function automatic logic uses_hilo(input logic [5:0] opcode, input logic [5:0] func);
      return (opcode == OP_SPECIAL) &&
             (func == FN_MFHI || func == FN_MFLO || func == FN_MULT ||
              func == FN_MULTU || func == FN_DIV || func == FN_DIVU);
   endfunction

endpackage

// File: rtl/execute_mdu.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per
// cycle on magnitudes, sign fixup and HI/LO update on the final step.
module mdu
   import mips_defs::*;
#(
   parameter int data_width = DATA_WIDTH,
   parameter int mdu_cycles = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  mdu_op_t               op,
   input  logic [data_width-1:0] a,
   input  logic [data_width-1:0] b,
   output logic                  busy,
   output logic [data_width-1:0] hi,
   output logic [data_width-1:0] lo
);
   localparam int CW = $clog2(mdu_cycles + 1);

   mdu_state_t state_reg, state_next;
   logic [CW-1:0] count_reg;
   logic [data_width-1:0] acc_hi_reg, acc_lo_reg, divisor_reg, dividend_reg;
   logic [data_width-1:0] hi_reg, lo_reg;
   logic is_div_reg, div_zero_reg, neg_q_reg, neg_r_reg;
   logic done;

   logic signed_op, a_neg, b_neg;
   logic [data_width-1:0] a_mag, b_mag;
   logic [data_width:0] mul_sum, div_shift, div_diff;
   logic div_ge;
   logic [data_width-1:0] step_hi, step_lo, fin_hi, fin_lo;
   logic [2*data_width-1:0] product;

   assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
   assign a_neg = signed_op & a[data_width-1];
   assign b_neg = signed_op & b[data_width-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   always_ff @(posedge clock) begin
      if (reset) state_reg <= MDU_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         MDU_IDLE: if (start) state_next = MDU_BUSY;
         MDU_BUSY: if (count_reg == '0) state_next = MDU_IDLE;
         default:  state_next = MDU_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_reg == MDU_BUSY);
      done = (state_reg == MDU_BUSY) && (count_reg == '0);
   end

   // acc_hi holds the partial product high half or the running remainder;
   // acc_lo holds the multiplier being shifted out or the quotient shifting in.
   always_comb begin
      mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, divisor_reg} : '0);
      div_shift = {acc_hi_reg, acc_lo_reg[data_width-1]};
      div_diff  = div_shift - {1'b0, divisor_reg};
      div_ge    = div_shift >= {1'b0, divisor_reg};
      if (is_div_reg) begin
         step_hi = div_ge ? div_diff[data_width-1:0] : div_shift[data_width-1:0];
         step_lo = {acc_lo_reg[data_width-2:0], div_ge};
      end else begin
         step_hi = mul_sum[data_width:1];
         step_lo = {mul_sum[0], acc_lo_reg[data_width-1:1]};
      end
      product = {step_hi, step_lo};
      if (neg_q_reg) product = -product;
      if (!is_div_reg) begin
         fin_hi = product[2*data_width-1:data_width];
         fin_lo = product[data_width-1:0];
      end else if (div_zero_reg) begin
         fin_hi = dividend_reg;
         fin_lo = '1;
      end else begin
         fin_hi = neg_r_reg ? -step_hi : step_hi;
         fin_lo = neg_q_reg ? -step_lo : step_lo;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_reg    <= '0;
         acc_hi_reg   <= '0;
         acc_lo_reg   <= '0;
         divisor_reg  <= '0;
         dividend_reg <= '0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         is_div_reg   <= 1'b0;
         div_zero_reg <= 1'b0;
         neg_q_reg    <= 1'b0;
         neg_r_reg    <= 1'b0;
      end else if (state_reg == MDU_IDLE && start) begin
         count_reg    <= CW'(mdu_cycles - 1);
         acc_hi_reg   <= '0;
         acc_lo_reg   <= a_mag;
         divisor_reg  <= b_mag;
         dividend_reg <= a;
         is_div_reg   <= (op == MDU_DIV) || (op == MDU_DIVU);
         div_zero_reg <= (b == '0);
         neg_q_reg    <= a_neg ^ b_neg;
         neg_r_reg    <= a_neg;
      end else if (busy) begin
         acc_hi_reg <= step_hi;
         acc_lo_reg <= step_lo;
         count_reg  <= count_reg - 1'b1;
         if (done) begin
            hi_reg <= fin_hi;
            lo_reg <= fin_lo;
         end
      end
   end

   assign hi = hi_reg;
   assign lo = lo_reg;

endmodule

// File: rtl/execute.sv
// MIPS execute stage: one-cycle ALU, branch/jump resolution and memory
// control, with an iterative MDU that stalls only HI/LO-dependent instructions.
module execute
   import mips_defs::*;
#(
   parameter int data_width = DATA_WIDTH,
   parameter int mdu_cycles = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable_execute,
   input  logic [5:0]            opcode_in,
   input  logic [4:0]            rd_in,
   input  logic [4:0]            rt_in,
   input  logic [4:0]            sa_in,
   input  logic [5:0]            func_in,
   input  logic [25:0]           imm_in,
   input  logic [31:0]           pc_in,
   input  logic [data_width-1:0] rs_data_in,
   input  logic [data_width-1:0] rt_data_in,
   output logic                  valid_out,
   output logic [data_width-1:0] alu_result_out,
   output logic [data_width-1:0] store_data_out,
   output logic [4:0]            dest_reg_out,
   output logic                  reg_write_out,
   output logic                  mem_read_out,
   output logic                  mem_write_out,
   output logic                  mem_byte_out,
   output logic                  mem_unsigned_out,
   output logic                  branch_taken_out,
   output logic [31:0]           branch_target_out,
   output logic                  stall_out
);
   logic mdu_busy, mdu_start;
   mdu_op_t mdu_op;
   logic [data_width-1:0] hi, lo;

   logic [31:0] pc_plus4, link, br_target, jump_target;
   logic [data_width-1:0] sext_imm, zext_imm;

   logic valid_next, wr_next, mrd_next, mwr_next, mbyte_next, munsigned_next, taken_next;
   logic [data_width-1:0] alu_next, store_next;
   logic [4:0] dest_next;
   logic [31:0] target_next;

   mdu #(.data_width(data_width), .mdu_cycles(mdu_cycles)) u_mdu (
      .clock (clock),
      .reset (reset),
      .start (mdu_start),
      .op    (mdu_op),
      .a     (rs_data_in),
      .b     (rt_data_in),
      .busy  (mdu_busy),
      .hi    (hi),
      .lo    (lo)
   );

   assign stall_out   = mdu_busy && enable_execute && uses_hilo(opcode_in, func_in);
   assign pc_plus4    = pc_in + 32'd4;
   assign link        = pc_in + 32'd8;
   assign br_target   = pc_plus4 + {{14{imm_in[15]}}, imm_in[15:0], 2'b00};
   assign jump_target = {pc_plus4[31:28], imm_in, 2'b00};
   assign sext_imm    = {{(data_width-16){imm_in[15]}}, imm_in[15:0]};
   assign zext_imm    = {{(data_width-16){1'b0}}, imm_in[15:0]};

   always_comb begin
      valid_next = 1'b0; wr_next = 1'b0; mrd_next = 1'b0; mwr_next = 1'b0;
      mbyte_next = 1'b0; munsigned_next = 1'b0; taken_next = 1'b0;
      alu_next = '0; store_next = '0; dest_next = '0; target_next = '0;
      mdu_start = 1'b0;
      mdu_op = mdu_op_t'(func_in[1:0]);
      if (enable_execute && !stall_out) begin
         valid_next = 1'b1;
         case (opcode_in)
            OP_SPECIAL: begin
               dest_next = rd_in;
               wr_next   = 1'b1;
               case (func_in)
                  FN_SLL:  alu_next = rt_data_in << sa_in;
                  FN_SRL:  alu_next = rt_data_in >> sa_in;
                  FN_SRA:  alu_next = $signed(rt_data_in) >>> sa_in;
                  FN_SLLV: alu_next = rt_data_in << rs_data_in[4:0];
                  FN_SRLV: alu_next = rt_data_in >> rs_data_in[4:0];
                  FN_SRAV: alu_next = $signed(rt_data_in) >>> rs_data_in[4:0];
                  FN_JR: begin
                     wr_next = 1'b0; taken_next = 1'b1; target_next = rs_data_in;
                  end
                  FN_JALR: begin
                     alu_next = link; taken_next = 1'b1; target_next = rs_data_in;
                  end
                  FN_MFHI: alu_next = hi;
                  FN_MFLO: alu_next = lo;
                  FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                     wr_next = 1'b0; mdu_start = 1'b1;
                  end
                  FN_ADD, FN_ADDU: alu_next = rs_data_in + rt_data_in;
                  FN_SUB, FN_SUBU: alu_next = rs_data_in - rt_data_in;
                  FN_AND:  alu_next = rs_data_in & rt_data_in;
                  FN_OR:   alu_next = rs_data_in | rt_data_in;
                  FN_XOR:  alu_next = rs_data_in ^ rt_data_in;
                  FN_NOR:  alu_next = ~(rs_data_in | rt_data_in);
                  FN_SLT:  alu_next = {{(data_width-1){1'b0}}, $signed(rs_data_in) < $signed(rt_data_in)};
                  FN_SLTU: alu_next = {{(data_width-1){1'b0}}, rs_data_in < rt_data_in};
                  default: begin
                     wr_next = 1'b0; dest_next = '0;
                  end
               endcase
            end
            OP_J:   begin taken_next = 1'b1; target_next = jump_target; end
            OP_JAL: begin
               taken_next = 1'b1; target_next = jump_target;
               alu_next = link; dest_next = 5'd31; wr_next = 1'b1;
            end
            OP_BEQ:  begin target_next = br_target; taken_next = (rs_data_in == rt_data_in); end
            OP_BNE:  begin target_next = br_target; taken_next = (rs_data_in != rt_data_in); end
            OP_BLEZ: begin target_next = br_target; taken_next = ($signed(rs_data_in) <= 0); end
            OP_BGTZ: begin target_next = br_target; taken_next = ($signed(rs_data_in) > 0); end
            OP_ADDI, OP_ADDIU: begin alu_next = rs_data_in + sext_imm; dest_next = rt_in; wr_next = 1'b1; end
            OP_SLTI: begin
               alu_next = {{(data_width-1){1'b0}}, $signed(rs_data_in) < $signed(sext_imm)};
               dest_next = rt_in; wr_next = 1'b1;
            end
            OP_SLTIU: begin
               alu_next = {{(data_width-1){1'b0}}, rs_data_in < sext_imm};
               dest_next = rt_in; wr_next = 1'b1;
            end
            OP_ANDI: begin alu_next = rs_data_in & zext_imm; dest_next = rt_in; wr_next = 1'b1; end
            OP_ORI:  begin alu_next = rs_data_in | zext_imm; dest_next = rt_in; wr_next = 1'b1; end
            OP_XORI: begin alu_next = rs_data_in ^ zext_imm; dest_next = rt_in; wr_next = 1'b1; end
            OP_LUI:  begin alu_next = {imm_in[15:0], {(data_width-16){1'b0}}}; dest_next = rt_in; wr_next = 1'b1; end
            OP_LW, OP_LB, OP_LBU: begin
               alu_next = rs_data_in + sext_imm; dest_next = rt_in; wr_next = 1'b1; mrd_next = 1'b1;
               mbyte_next = (opcode_in != OP_LW);
               munsigned_next = (opcode_in == OP_LBU);
            end
            OP_SW, OP_SB: begin
               alu_next = rs_data_in + sext_imm; store_next = rt_data_in; mwr_next = 1'b1;
               mbyte_next = (opcode_in == OP_SB);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_out <= 1'b0; alu_result_out <= '0; store_data_out <= '0; dest_reg_out <= '0;
         reg_write_out <= 1'b0; mem_read_out <= 1'b0; mem_write_out <= 1'b0; mem_byte_out <= 1'b0;
         mem_unsigned_out <= 1'b0; branch_taken_out <= 1'b0; branch_target_out <= '0;
      end else begin
         valid_out <= valid_next; alu_result_out <= alu_next; store_data_out <= store_next;
         dest_reg_out <= dest_next; reg_write_out <= wr_next && (dest_next != 5'd0);
         mem_read_out <= mrd_next; mem_write_out <= mwr_next; mem_byte_out <= mbyte_next;
         mem_unsigned_out <= munsigned_next; branch_taken_out <= taken_next;
         branch_target_out <= target_next;
      end
   end

endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage: ALU, branch/jump, memory control,
// MDU results and stall timing, reset abort of an in-flight divide.
module tb_execute;
   logic clock = 1'b0;
   logic reset, enable_execute;
   logic [5:0] opcode_in, func_in;
   logic [4:0] rd_in, rt_in, sa_in;
   logic [25:0] imm_in;
   logic [31:0] pc_in, rs_data_in, rt_data_in;
   logic valid_out, reg_write_out, mem_read_out, mem_write_out, mem_byte_out;
   logic mem_unsigned_out, branch_taken_out, stall_out;
   logic [31:0] alu_result_out, store_data_out, branch_target_out;
   logic [4:0] dest_reg_out;

   int vectors = 0;
   int miscompares = 0;
   int n;

   execute dut (
      .clock(clock), .reset(reset), .enable_execute(enable_execute),
      .opcode_in(opcode_in), .rd_in(rd_in), .rt_in(rt_in), .sa_in(sa_in),
      .func_in(func_in), .imm_in(imm_in), .pc_in(pc_in),
      .rs_data_in(rs_data_in), .rt_data_in(rt_data_in),
      .valid_out(valid_out), .alu_result_out(alu_result_out),
      .store_data_out(store_data_out), .dest_reg_out(dest_reg_out),
      .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
      .mem_write_out(mem_write_out), .mem_byte_out(mem_byte_out),
      .mem_unsigned_out(mem_unsigned_out), .branch_taken_out(branch_taken_out),
      .branch_target_out(branch_target_out), .stall_out(stall_out)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
      $display("vec %0d %s: observed %h expected %h", vectors, tag, got, exp);
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rd,
                        input logic [4:0] rt, input logic [4:0] sa, input logic [25:0] imm,
                        input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rtd);
      enable_execute = 1'b1; opcode_in = op; func_in = fn; rd_in = rd; rt_in = rt;
      sa_in = sa; imm_in = imm; pc_in = pc; rs_data_in = rs; rt_data_in = rtd;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Holds the current (stalled) instruction until stall_out drops, bounded.
   task automatic wait_stall(output int cycles);
      cycles = 0;
      #1;
      while (stall_out && cycles < 100) begin
         cycles++;
         tick();
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(6'h00, 6'h21, 5'd0, 5'd0, 5'd0, 26'd0, 32'd0, 32'd0, 32'd0);
      enable_execute = 1'b0;
      tick(); tick();
      check("reset valid", {31'd0, valid_out}, 32'd0);
      check("reset alu", alu_result_out, 32'd0);
      check("reset stall", {31'd0, stall_out}, 32'd0);
      reset = 1'b0;

      drive(6'h09, 6'h00, 5'd0, 5'd2, 5'd0, 26'h000FFFF, 32'h0, 32'd5, 32'd0);
      tick();
      check("addiu alu", alu_result_out, 32'd4);
      check("addiu dest", {27'd0, dest_reg_out}, 32'd2);
      check("addiu wr/valid", {30'd0, reg_write_out, valid_out}, 32'd3);

      drive(6'h04, 6'h00, 5'd0, 5'd0, 5'd0, 26'h0000003, 32'h80020010, 32'd7, 32'd7);
      tick();
      check("beq taken", {31'd0, branch_taken_out}, 32'd1);
      check("beq target", branch_target_out, 32'h80020020);
      check("beq wr", {31'd0, reg_write_out}, 32'd0);
      rt_data_in = 32'd8;
      tick();
      check("beq not taken", {31'd0, branch_taken_out}, 32'd0);

      drive(6'h00, 6'h18, 5'd0, 5'd0, 5'd0, 26'd0, 32'h0, 32'hFFFFFFFD, 32'd7);
      tick();
      check("mult retire", {30'd0, valid_out, reg_write_out}, 32'd2);
      drive(6'h00, 6'h12, 5'd4, 5'd0, 5'd0, 26'd0, 32'h0, 32'd0, 32'd0);
      wait_stall(n);
      check("mult stall cycles", n, 32'd32);
      tick();
      check("mflo after mult", alu_result_out, 32'hFFFFFFEB);
      check("mflo dest/wr", {26'd0, dest_reg_out, reg_write_out}, {26'd0, 5'd4, 1'b1});
      drive(6'h00, 6'h10, 5'd5, 5'd0, 5'd0, 26'd0, 32'h0, 32'd0, 32'd0);
      tick();
      check("mfhi after mult", alu_result_out, 32'hFFFFFFFF);

      drive(6'h00, 6'h1A, 5'd0, 5'd0, 5'd0, 26'd0, 32'h0, 32'hFFFFFFF9, 32'd2);
      tick();
      drive(6'h00, 6'h12, 5'd4, 5'd0, 5'd0, 26'd0, 32'h0, 32'd0, 32'd0);
      wait_stall(n);
      check("div stall cycles", n, 32'd32);
      tick();
      check("div lo", alu_result_out, 32'hFFFFFFFD);
      drive(6'h00, 6'h10, 5'd5, 5'd0, 5'd0, 26'd0, 32'h0, 32'd0, 32'd0);
      tick();
      check("div hi", alu_result_out, 32'hFFFFFFFF);

      drive(6'h00, 6'h1B, 5'd0, 5'd0, 5'd0, 26'd0, 32'h0, 32'd9, 32'd0);
      tick();
      drive(6'h00, 6'h12, 5'd4, 5'd0, 5'd0, 26'd0, 32'h0, 32'd0, 32'd0);
      wait_stall(n);
      check("divu0 stall cycles", n, 32'd32);
      tick();
      check("divu0 lo", alu_result_out, 32'hFFFFFFFF);
      drive(6'h00, 6'h10, 5'd5, 5'd0, 5'd0, 26'd0, 32'h0, 32'd0, 32'd0);
      tick();
      check("divu0 hi", alu_result_out, 32'd9);

      // DIVU accepted at edge 0, ADDU at edge 1, reset sampled at edge 10.
      drive(6'h00, 6'h1B, 5'd0, 5'd0, 5'd0, 26'd0, 32'h0, 32'd100, 32'd7);
      tick();
      drive(6'h00, 6'h21, 5'd3, 5'd0, 5'd0, 26'd0, 32'h0, 32'd1, 32'd2);
      #1;
      check("addu busy stall", {31'd0, stall_out}, 32'd0);
      tick();
      check("addu busy alu", alu_result_out, 32'd3);
      check("addu busy dest/wr/valid", {25'd0, dest_reg_out, reg_write_out, valid_out},
            {25'd0, 5'd3, 1'b1, 1'b1});
      enable_execute = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      drive(6'h00, 6'h12, 5'd4, 5'd0, 5'd0, 26'd0, 32'h0, 32'd0, 32'd0);
      reset = 1'b1;
      tick();
      check("abort valid", {31'd0, valid_out}, 32'd0);
      check("abort alu", alu_result_out, 32'd0);
      check("abort dest/wr", {26'd0, dest_reg_out, reg_write_out}, 32'd0);
      check("abort stall", {31'd0, stall_out}, 32'd0);
      reset = 1'b0;
      tick();
      check("abort lo", alu_result_out, 32'd0);
      check("abort lo valid", {31'd0, valid_out}, 32'd1);
      drive(6'h00, 6'h10, 5'd5, 5'd0, 5'd0, 26'd0, 32'h0, 32'd0, 32'd0);
      tick();
      check("abort hi", alu_result_out, 32'd0);

      drive(6'h00, 6'h21, 5'd0, 5'd0, 5'd0, 26'd0, 32'h0, 32'd1, 32'd2);
      tick();
      check("addu r0 wr", {31'd0, reg_write_out}, 32'd0);

      drive(6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 26'h0000010, 32'h80020000, 32'd0, 32'd0);
      tick();
      check("jal target", branch_target_out, 32'h80000040);
      check("jal dest", {27'd0, dest_reg_out}, 32'd31);
      check("jal link", alu_result_out, 32'h80020008);

      drive(6'h0D, 6'h00, 5'd0, 5'd7, 5'd0, 26'h0008001, 32'h0, 32'h12340000, 32'd0);
      tick();
      check("ori zext", alu_result_out, 32'h12348001);

      drive(6'h00, 6'h03, 5'd8, 5'd0, 5'd4, 26'd0, 32'h0, 32'd0, 32'h80000000);
      tick();
      check("sra", alu_result_out, 32'hF8000000);

      drive(6'h24, 6'h00, 5'd0, 5'd6, 5'd0, 26'h0000003, 32'h0, 32'h1000, 32'd0);
      tick();
      check("lbu addr", alu_result_out, 32'h1003);
      check("lbu ctl", {27'd0, mem_read_out, mem_write_out, mem_byte_out, mem_unsigned_out, reg_write_out},
            32'b10111);

      drive(6'h2B, 6'h00, 5'd0, 5'd4, 5'd0, 26'h000FFFC, 32'h0, 32'h100, 32'hCAFEF00D);
      tick();
      check("sw addr", alu_result_out, 32'h000000FC);
      check("sw data", store_data_out, 32'hCAFEF00D);
      check("sw ctl", {28'd0, mem_read_out, mem_write_out, mem_byte_out, reg_write_out}, 32'b0100);

      drive(6'h3F, 6'h00, 5'd9, 5'd9, 5'd0, 26'd5, 32'h0, 32'd1, 32'd1);
      tick();
      check("unknown valid/wr", {30'd0, valid_out, reg_write_out}, 32'd2);

      enable_execute = 1'b0;
      tick();
      check("bubble valid", {31'd0, valid_out}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
